// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: register-master FSM state encoding and response codes.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_timeout_counter.sv
// Per-transaction watchdog: reloads on clr, counts down while en, flags the last allowed cycle.
module axi_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= LOAD;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  // count reaches zero on the TIMEOUT_CYCLES-th enabled cycle
  assign expired = en && (count == '0);

endmodule

// File: rtl/axi_lite_reg_master.sv
// Single-outstanding AXI-Lite register master: one command in, one AXI transaction, one response out.
module axi_lite_reg_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int STROBE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_data,
  input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_rsp_timeout,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [1:0]              i_rresp,
  input  logic [DATA_WIDTH-1:0]   i_rdata
);

  state_t state, state_nxt;

  logic                    cmd_accept;
  logic                    aw_hs, w_hs;
  logic                    aw_done, w_done;
  logic                    active;
  logic                    expired;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [STROBE_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic [1:0]              rsp_resp_q;
  logic                    rsp_timeout_q;

  assign cmd_accept = i_cmd_valid && o_cmd_ready;
  assign aw_hs      = o_awvalid && i_awready;
  assign w_hs       = o_wvalid && i_wready;
  assign active     = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                      (state == RD_ADDR) || (state == RD_DATA);

  axi_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (cmd_accept),
    .en     (active),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A final response arriving on the expiring cycle still completes normally.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          state_nxt = i_cmd_write ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        if (expired) begin
          state_nxt = RSP;
        end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (i_bvalid || expired) begin
          state_nxt = RSP;
        end
      end
      RD_ADDR: begin
        if (expired) begin
          state_nxt = RSP;
        end else if (i_arready) begin
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (i_rvalid || expired) begin
          state_nxt = RSP;
        end
      end
      RSP: begin
        if (i_rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_bready    = 1'b0;
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_rsp_valid = 1'b0;
    case (state)
      IDLE:         o_cmd_ready = !rst;
      WR_ADDR_DATA: begin
        o_awvalid = !aw_done;
        o_wvalid  = !w_done;
      end
      WR_RESP:      o_bready    = 1'b1;
      RD_ADDR:      o_arvalid   = 1'b1;
      RD_DATA:      o_rready    = 1'b1;
      RSP:          o_rsp_valid = 1'b1;
      default:      o_cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      data_q        <= '0;
      strb_q        <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (cmd_accept) begin
        addr_q  <= i_cmd_addr;
        data_q  <= i_cmd_data;
        strb_q  <= i_cmd_strb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
      if ((state == WR_RESP) && i_bvalid) begin
        rsp_data_q    <= '0;
        rsp_resp_q    <= i_bresp;
        rsp_timeout_q <= 1'b0;
      end else if ((state == RD_DATA) && i_rvalid) begin
        rsp_data_q    <= i_rdata;
        rsp_resp_q    <= i_rresp;
        rsp_timeout_q <= 1'b0;
      end else if (expired) begin
        rsp_data_q    <= '0;
        rsp_resp_q    <= RESP_SLVERR;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign o_awaddr      = addr_q;
  assign o_araddr      = addr_q;
  assign o_wdata       = data_q;
  assign o_wstrb       = strb_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Directed bench for axi_lite_reg_master against a two-register AXI-Lite slave model.
module tb_axi_lite_reg_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_data;
  logic [SW-1:0] i_cmd_strb;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_timeout;
  logic [DW-1:0] o_rsp_data;
  logic [1:0]    o_rsp_resp;
  logic          o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [AW-1:0] o_awaddr, o_araddr;
  logic [DW-1:0] o_wdata, i_rdata;
  logic [SW-1:0] o_wstrb;
  logic [1:0]    i_bresp, i_rresp;
  logic          o_arvalid, i_arready, i_rvalid, o_rready;

  int tests = 0;
  int fails = 0;

  axi_lite_reg_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
  );

  // Slave model: registers at 0x0 and 0x4, DECERR elsewhere; reacts on the falling edge.
  int            aw_delay = 0;
  int            aw_wait  = 0;
  bit            ar_block = 1'b0;
  bit            b_block  = 1'b0;
  bit            spur     = 1'b0;
  logic [DW-1:0] mem [0:1];
  logic          aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
  logic [AW-1:0] aw_a, ar_a;
  logic [DW-1:0] w_d;
  logic [SW-1:0] w_s;

  function automatic logic [1:0] dec(input logic [AW-1:0] a);
    return ((a == 32'h0) || (a == 32'h4)) ? 2'b00 : 2'b11;
  endfunction

  always @(negedge clk) begin
    if (o_awvalid === 1'b1) begin
      i_awready = (aw_wait >= aw_delay);
      aw_wait++;
    end else begin
      i_awready = 1'b0;
      aw_wait   = 0;
    end
    i_wready  = (o_wvalid === 1'b1);
    i_arready = (o_arvalid === 1'b1) && !ar_block;
    if ((o_bready === 1'b1) && aw_got && w_got && !b_block) begin
      i_bvalid = 1'b1;
      i_bresp  = dec(aw_a);
      if (dec(aw_a) == 2'b00) begin
        for (int b = 0; b < SW; b++) begin
          if (w_s[b]) mem[aw_a[2]][8*b +: 8] = w_d[8*b +: 8];
        end
      end
    end else begin
      i_bvalid = spur;
      i_bresp  = 2'b00;
    end
    if ((o_rready === 1'b1) && ar_got) begin
      i_rvalid = 1'b1;
      i_rresp  = dec(ar_a);
      i_rdata  = (dec(ar_a) == 2'b00) ? mem[ar_a[2]] : '0;
    end else begin
      i_rvalid = spur;
      i_rresp  = 2'b00;
      i_rdata  = '0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      ar_got <= 1'b0;
    end else begin
      if (o_awvalid && i_awready) begin aw_got <= 1'b1; aw_a <= o_awaddr; end
      if (o_wvalid && i_wready) begin w_got <= 1'b1; w_d <= o_wdata; w_s <= o_wstrb; end
      if (o_bready && i_bvalid) begin aw_got <= 1'b0; w_got <= 1'b0; end
      if (o_arvalid && i_arready) begin ar_got <= 1'b1; ar_a <= o_araddr; end
      if (o_rready && i_rvalid) ar_got <= 1'b0;
    end
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    @(negedge clk);
    for (int i = 0; i < 50 && !o_cmd_ready; i++) @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = a;
    i_cmd_data  = d;
    i_cmd_strb  = s;
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!o_rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack_rsp();
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
  endtask

  task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output int lat, output logic [DW-1:0] rd,
                        output logic [1:0] rr, output logic tmo);
    send_cmd(wr, a, d, s);
    wait_rsp(lat);
    rd  = o_rsp_data;
    rr  = o_rsp_resp;
    tmo = o_rsp_timeout;
    ack_rsp();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid,
         o_rsp_timeout} !== 8'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 00000000", {o_cmd_ready, o_awvalid, o_wvalid,
               o_bready, o_arvalid, o_rready, o_rsp_valid, o_rsp_timeout});
    end
    tests++;
    if ({o_awaddr, o_wdata, o_wstrb, o_araddr, o_rsp_data, o_rsp_resp} !== '0) begin
      fails++;
      $display("FAIL reset_regs: awaddr %h wdata %h wstrb %h araddr %h rsp_data %h resp %h want 0",
               o_awaddr, o_wdata, o_wstrb, o_araddr, o_rsp_data, o_rsp_resp);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (o_cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 1", o_cmd_ready);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [DW-1:0] rd; logic [1:0] rr; logic tmo;
    do_txn(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, lat, rd, rr, tmo);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", lat); end
    tests++;
    if ({rd, rr, tmo} !== 35'h0) begin
      fails++;
      $display("FAIL wr_rsp: data %h resp %h tmo %b want 0 0 0", rd, rr, tmo);
    end
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, rr, tmo);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d want 3", lat); end
    tests++;
    if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    tests++;
    if ({rr, tmo} !== 3'b000) begin
      fails++;
      $display("FAIL rd_resp: resp %h tmo %b want 0 0", rr, tmo);
    end
  endtask

  task automatic test_aw_delay();
    int lat, awc, wc, bad, extra; logic [DW-1:0] rd; logic [1:0] rr; logic tmo;
    aw_delay = 3;
    send_cmd(1'b1, 32'h4, 32'h12345678, 4'hF);
    lat = 1; awc = 0; wc = 0; bad = 0;
    while (!o_rsp_valid && lat < 200) begin
      if (o_awvalid) begin
        awc++;
        if (o_awaddr !== 32'h4) bad++;
      end
      if (o_wvalid) begin
        wc++;
        if ((o_wdata !== 32'h12345678) || (o_wstrb !== 4'hF)) bad++;
      end
      @(negedge clk);
      lat++;
    end
    rr = o_rsp_resp;
    ack_rsp();
    aw_delay = 0;
    extra = 0;
    repeat (4) begin
      if (o_rsp_valid) extra++;
      @(negedge clk);
    end
    tests++;
    if (awc !== 4) begin fails++; $display("FAIL awvalid_cycles: got %0d want 4", awc); end
    tests++;
    if (wc !== 1) begin fails++; $display("FAIL wvalid_cycles: got %0d want 1", wc); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL aw_w_stable: got %0d unstable want 0", bad); end
    tests++;
    if (lat !== 6) begin fails++; $display("FAIL awdelay_latency: got %0d want 6", lat); end
    tests++;
    if ((rr !== 2'b00) || (extra !== 0)) begin
      fails++;
      $display("FAIL awdelay_single_rsp: resp %h extra %0d want 0 0", rr, extra);
    end
    do_txn(1'b0, 32'h4, 32'h0, 4'h0, lat, rd, rr, tmo);
    tests++;
    if (rd !== 32'h12345678) begin fails++; $display("FAIL readback4: got %h want 12345678", rd); end
  endtask

  task automatic test_bad_read();
    int lat; logic [DW-1:0] rd; logic [1:0] rr; logic tmo;
    do_txn(1'b0, 32'h8, 32'h0, 4'h0, lat, rd, rr, tmo);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL bad_rd_data: got %h want 0", rd); end
    tests++;
    if (rr !== 2'b11) begin fails++; $display("FAIL bad_rd_resp: got %h want 3", rr); end
    tests++;
    if ((tmo !== 1'b0) || (lat !== 3)) begin
      fails++;
      $display("FAIL bad_rd_tmo: tmo %b lat %0d want 0 3", tmo, lat);
    end
  endtask

  task automatic test_timeout();
    int lat, arc; logic [DW-1:0] rd; logic [1:0] rr; logic tmo;
    ar_block = 1'b1;
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
    lat = 1; arc = 0;
    while (!o_rsp_valid && lat < 200) begin
      if (o_arvalid) arc++;
      @(negedge clk);
      lat++;
    end
    tests++;
    if ((arc !== TMO) || (lat !== TMO + 1)) begin
      fails++;
      $display("FAIL tmo_cycles: arvalid %0d lat %0d want %0d %0d", arc, lat, TMO, TMO + 1);
    end
    tests++;
    if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready} !== 5'b0) begin
      fails++;
      $display("FAIL tmo_axi_drop: got %b want 00000",
               {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready});
    end
    tests++;
    if ({o_rsp_timeout, o_rsp_resp, o_rsp_data} !== {1'b1, 2'b10, 32'h0}) begin
      fails++;
      $display("FAIL tmo_rsp: tmo %b resp %h data %h want 1 2 0",
               o_rsp_timeout, o_rsp_resp, o_rsp_data);
    end
    ack_rsp();
    ar_block = 1'b0;
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, rr, tmo);
    tests++;
    if ({rd, rr, tmo} !== {32'hDEADBEEF, 2'b00, 1'b0} || (lat !== 3)) begin
      fails++;
      $display("FAIL tmo_recover: data %h resp %h tmo %b lat %0d want deadbeef 0 0 3",
               rd, rr, tmo, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat, bad; logic [DW-1:0] rd; logic [1:0] rr; logic tmo;
    do_txn(1'b1, 32'h0, 32'h11223344, 4'b0101, lat, rd, rr, tmo);
    tests++;
    if (rr !== 2'b00) begin fails++; $display("FAIL strb_wr_resp: got %h want 0", rr); end
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
    wait_rsp(lat);
    bad = 0;
    repeat (5) begin
      if ((o_rsp_valid !== 1'b1) || (o_rsp_data !== 32'hDE22BE44) || (o_rsp_resp !== 2'b00) ||
          (o_cmd_ready !== 1'b0)) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL rsp_hold: %0d bad cycles, last data %h want de22be44 held", bad, o_rsp_data);
    end
    ack_rsp();
    tests++;
    if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
      fails++;
      $display("FAIL rsp_release: valid %b ready %b want 0 1", o_rsp_valid, o_cmd_ready);
    end
  endtask

  task automatic test_spurious();
    int bad;
    bad  = 0;
    spur = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (o_rsp_valid || o_bready || o_rready) bad++;
    end
    spur = 1'b0;
    @(negedge clk);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL spurious_rsp: got %0d want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic [DW-1:0] rd; logic [1:0] rr; logic tmo;
    b_block = 1'b1;
    send_cmd(1'b1, 32'h4, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 50 && !o_bready; i++) @(negedge clk);
    tests++;
    if (o_bready !== 1'b1) begin fails++; $display("FAIL reach_wr_resp: bready %b want 1", o_bready); end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid,
         o_rsp_timeout, o_awaddr, o_wdata} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: ctrl %b awaddr %h wdata %h want 0",
               {o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid,
                o_rsp_timeout}, o_awaddr, o_wdata);
    end
    rst     = 1'b0;
    b_block = 1'b0;
    seen    = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_rsp_valid) seen++;
    end
    tests++;
    if ((seen !== 0) || (o_cmd_ready !== 1'b1)) begin
      fails++;
      $display("FAIL midrst_idle: rsp_valid cycles %0d ready %b want 0 1", seen, o_cmd_ready);
    end
    do_txn(1'b0, 32'h4, 32'h0, 4'h0, lat, rd, rr, tmo);
    tests++;
    if (rd !== 32'h12345678) begin fails++; $display("FAIL midrst_readback: got %h want 12345678", rd); end
  endtask

  initial begin
    mem[0]      = '0;
    mem[1]      = '0;
    rst         = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_data  = '0;
    i_cmd_strb  = '0;
    i_rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_aw_delay();
    test_bad_read();
    test_timeout();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
